// File: rtl/vdp_pkg.sv
// Shared constants and types for the VDP CPU port: I/O port decode values,
// default sizes, VRAM sequencer states and status-register bit positions.
package vdp_pkg;
  localparam logic [7:0] PORT_DATA    = 8'h98;
  localparam logic [7:0] PORT_CTRL    = 8'h99;
  localparam int         DEF_ADDR_W   = 14;
  localparam int         DEF_NUM_REGS = 8;

  typedef enum logic [1:0] {IDLE, WRITE, READ} seq_state_e;

  localparam int         ST_INT    = 7;
  localparam int         ST_5S     = 6;
  localparam int         ST_COL    = 5;
  localparam logic [4:0] NO_5S_NUM = 5'h1F;
  localparam int         R1_IE     = 5;
endpackage

// File: rtl/vdp_cpu_port_if.sv
// CPU bus, VRAM request port, register file and status signals of vdp_cpu_port.
interface vdp_cpu_port_if #(
  parameter int NUM_REGS = 8,
  parameter int ADDR_W   = 14
);
  logic                  clk_ena;
  logic [7:0]            io_addr;
  logic                  n_io_rd;
  logic                  n_io_wr;
  logic [7:0]            din;
  logic [7:0]            dout;
  logic                  wait_n;
  logic                  vram_req;
  logic                  vram_we;
  logic [ADDR_W-1:0]     vram_addr;
  logic [7:0]            vram_wdata;
  logic                  vram_ack;
  logic [7:0]            vram_rdata;
  logic [8*NUM_REGS-1:0] regs;
  logic                  int_pulse;
  logic                  coll_pulse;
  logic                  fifth_spr;
  logic [4:0]            fifth_num;
  logic                  n_int;

  modport slave (
    input  clk_ena, io_addr, n_io_rd, n_io_wr, din, vram_ack, vram_rdata,
           int_pulse, coll_pulse, fifth_spr, fifth_num,
    output dout, wait_n, vram_req, vram_we, vram_addr, vram_wdata, regs, n_int
  );

  modport master (
    output clk_ena, io_addr, n_io_rd, n_io_wr, din, vram_ack, vram_rdata,
           int_pulse, coll_pulse, fifth_spr, fifth_num,
    input  dout, wait_n, vram_req, vram_we, vram_addr, vram_wdata, regs, n_int
  );
endinterface

// File: rtl/vdp_vram_seq.sv
// VRAM access sequencer: owns the auto-incrementing VRAM address, the read-ahead
// buffer and the req/ack handshake towards the video block arbiter.
module vdp_vram_seq import vdp_pkg::*; #(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic              i_we,
  input  logic [7:0]        i_wdata,
  input  logic              i_ld,
  input  logic [ADDR_W-1:0] i_ld_addr,
  input  logic              i_ack,
  input  logic [7:0]        i_rdata,
  output logic              o_busy,
  output logic              o_req,
  output logic              o_we,
  output logic [ADDR_W-1:0] o_addr,
  output logic [7:0]        o_wdata,
  output logic [7:0]        o_rd_buf
);
  seq_state_e        r_state, w_state_nxt;
  logic              w_start, w_ack;
  logic              r_sup, r_we;
  logic [ADDR_W-1:0] r_vaddr, r_addr;
  logic [7:0]        r_wdata, r_rd_buf;

  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_ack       = 1'b0;
    case (r_state)
      IDLE: if (i_req) begin
        w_start     = 1'b1;
        w_state_nxt = i_we ? WRITE : READ;
      end
      WRITE, READ: if (i_ack) begin
        w_ack       = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // An address reload during an access wins over that access's post-ack increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vaddr  <= '0;
      r_sup    <= 1'b0;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rd_buf <= '0;
    end else begin
      if (i_ld)                r_vaddr <= i_ld_addr;
      else if (w_ack && !r_sup) r_vaddr <= r_vaddr + ADDR_W'(1);
      r_sup <= (r_state != IDLE) && !w_ack && (i_ld || r_sup);
      if (w_start) begin
        r_we    <= i_we;
        r_addr  <= i_ld ? i_ld_addr : r_vaddr;
        r_wdata <= i_wdata;
      end
      if (w_ack && r_state == READ) r_rd_buf <= i_rdata;
    end
  end

  assign o_busy   = (r_state != IDLE);
  assign o_req    = o_busy;
  assign o_we     = r_we;
  assign o_addr   = r_addr;
  assign o_wdata  = r_wdata;
  assign o_rd_buf = r_rd_buf;
endmodule

// File: rtl/vdp_cpu_port.sv
// Z80-side port of the VDP: I/O decode, address/register latch, register file,
// status flags. VDP_WAIT_EN: stall and replay data-port accesses hitting a busy sequencer.
module vdp_cpu_port import vdp_pkg::*; #(
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int ADDR_W   = DEF_ADDR_W
) (
  input logic           clk,
  input logic           reset,
  vdp_cpu_port_if.slave bus
);
  localparam int RIDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  logic                         r_acc_prev, r_rd_act, r_rd_ctrl, r_rd_drop;
  logic                         r_toggle, r_int, r_coll;
  logic [7:0]                   r_first;
  logic [NUM_REGS-1:0][7:0]     r_regs;
  logic                         r_slot_vld, r_slot_we;
  logic [7:0]                   r_slot_wd;
  logic                         w_sel_data, w_sel_ctrl, w_acc, w_ev, w_ev_rd, w_ev_wr;
  logic                         w_cwr, w_dwr, w_dev, w_eor, w_ctrl_eor, w_data_eor;
  logic                         w_addr_wr, w_reg_wr, w_busy, w_hold, w_drop;
  logic                         w_new_vld, w_new_we, w_q_req, w_q_we;
  logic [7:0]                   w_q_wd, w_rd_buf, w_status;
  logic [13:0]                  w_ld_full;

  assign w_sel_data = (bus.io_addr == PORT_DATA);
  assign w_sel_ctrl = (bus.io_addr == PORT_CTRL);
  assign w_acc      = (w_sel_data | w_sel_ctrl) & (~bus.n_io_rd | ~bus.n_io_wr);
  assign w_ev       = bus.clk_ena & w_acc & ~r_acc_prev;
  assign w_ev_rd    = w_ev & ~bus.n_io_rd;
  assign w_ev_wr    = w_ev & bus.n_io_rd;
  assign w_cwr      = w_ev_wr & w_sel_ctrl;
  assign w_dwr      = w_ev_wr & w_sel_data;
  assign w_dev      = w_ev & w_sel_data;
  assign w_eor      = bus.clk_ena & r_rd_act & bus.n_io_rd;
  assign w_ctrl_eor = w_eor & r_rd_ctrl;
  assign w_data_eor = w_eor & ~r_rd_ctrl & ~r_rd_drop;

  assign w_ld_full  = {bus.din[5:0], r_first};
  assign w_addr_wr  = w_cwr & r_toggle & ~bus.din[7];
  assign w_reg_wr   = w_cwr & r_toggle & bus.din[7] & (int'(bus.din[5:0]) < NUM_REGS);

  // A held slot counts as busy so a new access never overtakes a queued one.
  assign w_hold = w_dev & (w_busy | r_slot_vld);

`ifdef VDP_WAIT_EN
  logic r_wait;
  always_ff @(posedge clk or posedge reset)
    if (reset)        r_wait <= 1'b0;
    else if (w_hold)  r_wait <= 1'b1;
    else if (!w_busy) r_wait <= 1'b0;
  assign w_drop     = 1'b0;
  assign bus.wait_n = ~((r_wait & w_busy) | w_hold);
`else
  assign w_drop     = w_hold;
  assign bus.wait_n = 1'b1;
`endif

  assign w_new_we  = w_dwr & ~w_drop;
  assign w_new_vld = w_new_we | (w_addr_wr & ~bus.din[6]) | w_data_eor;
  assign w_q_req   = ~w_busy & (r_slot_vld | w_new_vld);
  assign w_q_we    = r_slot_vld ? r_slot_we : w_new_we;
  assign w_q_wd    = r_slot_vld ? r_slot_wd : bus.din;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_acc_prev <= 1'b0;
      r_rd_act   <= 1'b0;
      r_rd_ctrl  <= 1'b0;
      r_rd_drop  <= 1'b0;
      r_toggle   <= 1'b0;
      r_first    <= '0;
      r_regs     <= '0;
      r_int      <= 1'b0;
      r_coll     <= 1'b0;
      r_slot_vld <= 1'b0;
      r_slot_we  <= 1'b0;
      r_slot_wd  <= '0;
    end else begin
      if (bus.clk_ena) r_acc_prev <= w_acc;
      if (w_ev_rd) begin
        r_rd_act  <= 1'b1;
        r_rd_ctrl <= w_sel_ctrl;
        r_rd_drop <= w_drop;
      end else if (w_eor) r_rd_act <= 1'b0;
      if (w_cwr) begin
        r_toggle <= ~r_toggle;
        if (!r_toggle) r_first <= bus.din;
      end else if (w_dev | w_ctrl_eor) r_toggle <= 1'b0;
      if (w_reg_wr) r_regs[bus.din[RIDX_W-1:0]] <= r_first;
      r_int  <= bus.int_pulse  | (r_int  & ~w_ctrl_eor);
      r_coll <= bus.coll_pulse | (r_coll & ~w_ctrl_eor);
      if (~w_busy & r_slot_vld) begin
        r_slot_vld <= w_new_vld;
        r_slot_we  <= w_new_we;
        r_slot_wd  <= bus.din;
      end else if (w_busy & w_new_vld) begin
        r_slot_vld <= 1'b1;
        r_slot_we  <= w_new_we;
        r_slot_wd  <= bus.din;
      end
    end
  end

  vdp_vram_seq #(.ADDR_W(ADDR_W)) u_seq (
    .clk       (clk),
    .rst       (reset),
    .i_req     (w_q_req),
    .i_we      (w_q_we),
    .i_wdata   (w_q_wd),
    .i_ld      (w_addr_wr),
    .i_ld_addr (ADDR_W'(w_ld_full)),
    .i_ack     (bus.vram_ack),
    .i_rdata   (bus.vram_rdata),
    .o_busy    (w_busy),
    .o_req     (bus.vram_req),
    .o_we      (bus.vram_we),
    .o_addr    (bus.vram_addr),
    .o_wdata   (bus.vram_wdata),
    .o_rd_buf  (w_rd_buf)
  );

  always_comb begin
    w_status         = {3'b000, bus.fifth_spr ? bus.fifth_num : NO_5S_NUM};
    w_status[ST_INT] = r_int;
    w_status[ST_5S]  = bus.fifth_spr;
    w_status[ST_COL] = r_coll;
  end

  assign bus.dout  = (~bus.n_io_rd & w_sel_ctrl) ? w_status :
                     (~bus.n_io_rd & w_sel_data) ? w_rd_buf : 8'h00;
  assign bus.regs  = r_regs;
  assign bus.n_int = ~(r_int & r_regs[1][R1_IE]);
endmodule

// File: tb/tb_vdp_cpu_port.sv
// Directed bench for vdp_cpu_port with a behavioural VRAM responder.
module tb_vdp_cpu_port;
  import vdp_pkg::*;

`ifdef VDP_WAIT_EN
  localparam bit WEN = 1'b1;
`else
  localparam bit WEN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  vdp_cpu_port_if #(.NUM_REGS(8), .ADDR_W(14)) bus();
  vdp_cpu_port #(.NUM_REGS(8), .ADDR_W(14)) dut (.clk(clk), .reset(reset), .bus(bus));

  int          n_chk = 0, n_fail = 0;
  logic [7:0]  mem [0:16383];
  int          ack_delay = 1, lat_cnt = 0, wr_cnt = 0, rd_cnt = 0;
  logic [13:0] last_wa = '0, last_ra = '0;
  logic [7:0]  last_wd = '0, rdv;
  logic        req_seen;
  int          w0, r0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // VRAM responder: acks after ack_delay cycles of request, logs each access.
  initial begin
    bus.vram_ack   = 1'b0;
    bus.vram_rdata = 8'h00;
    forever begin
      @(negedge clk);
      if (bus.vram_req && !bus.vram_ack && lat_cnt >= ack_delay) begin
        bus.vram_ack   = 1'b1;
        bus.vram_rdata = mem[bus.vram_addr];
        if (bus.vram_we) begin
          mem[bus.vram_addr] = bus.vram_wdata;
          wr_cnt++;
          last_wa = bus.vram_addr;
          last_wd = bus.vram_wdata;
        end else begin
          rd_cnt++;
          last_ra = bus.vram_addr;
        end
        lat_cnt = 0;
      end else begin
        bus.vram_ack = 1'b0;
        lat_cnt = bus.vram_req ? lat_cnt + 1 : 0;
      end
    end
  end

  task automatic io_wr(input logic [7:0] port, input logic [7:0] data);
    @(negedge clk);
    bus.io_addr = port; bus.din = data; bus.n_io_wr = 1'b0;
    @(negedge clk);
    req_seen = bus.vram_req;
    for (int i = 0; i < 100 && !bus.wait_n; i++) @(negedge clk);
    if (!bus.wait_n) chk("wr_wait_timeout", bus.wait_n, 1);
    bus.n_io_wr = 1'b1; bus.io_addr = 8'h00;
    @(negedge clk);
  endtask

  task automatic io_rd(input logic [7:0] port, output logic [7:0] data);
    @(negedge clk);
    bus.io_addr = port; bus.n_io_rd = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 100 && !bus.wait_n; i++) @(negedge clk);
    if (!bus.wait_n) chk("rd_wait_timeout", bus.wait_n, 1);
    data = bus.dout;
    bus.n_io_rd = 1'b1; bus.io_addr = 8'h00;
    @(negedge clk);
  endtask

  task automatic settle();
    int q = 0;
    for (int i = 0; i < 300 && q < 3; i++) begin
      @(negedge clk);
      q = bus.vram_req ? 0 : q + 1;
    end
    if (q < 3) chk("settle_timeout", q, 3);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = 8'h00;
    reset = 1'b1;
    bus.clk_ena = 1'b1; bus.io_addr = 8'h00; bus.n_io_rd = 1'b1; bus.n_io_wr = 1'b1;
    bus.din = 8'h00; bus.int_pulse = 1'b0; bus.coll_pulse = 1'b0;
    bus.fifth_spr = 1'b0; bus.fifth_num = 5'h00;
    repeat (3) @(negedge clk);
    chk("rst_req",  bus.vram_req, 0);
    chk("rst_we",   bus.vram_we,  0);
    chk("rst_dout", bus.dout,     0);
    chk("rst_wait", bus.wait_n,   1);
    chk("rst_nint", bus.n_int,    1);
    chk("rst_regs", bus.regs,     0);
    reset = 1'b0;

    // address set and post-ack increment
    io_wr(8'h99, 8'h34); io_wr(8'h99, 8'h52);
    w0 = wr_cnt;
    io_wr(8'h98, 8'hAA);
    chk("req_latency", req_seen, 1);
    settle();
    chk("aset_cnt",  wr_cnt - w0, 1);
    chk("aset_addr", last_wa, 14'h1234);
    chk("aset_data", last_wd, 8'hAA);
    io_wr(8'h98, 8'h55); settle();
    chk("aset_incr", last_wa, 14'h1235);

    // register file
    io_wr(8'h99, 8'hE0); io_wr(8'h99, 8'h81);
    chk("reg1", bus.regs[15:8], 8'hE0);
    io_wr(8'h99, 8'hF4); io_wr(8'h99, 8'h87);
    chk("reg7", bus.regs[63:56], 8'hF4);
    io_wr(8'h99, 8'h5A); io_wr(8'h99, 8'h88);
    chk("reg_oob", bus.regs, 64'hF400_0000_0000_E000);
    io_wr(8'h99, 8'h00); io_wr(8'h98, 8'h66); settle();
    io_wr(8'h99, 8'hC5); io_wr(8'h99, 8'h80);
    chk("data_clr_toggle", bus.regs[7:0], 8'hC5);

    // read-ahead
    mem[14'h0100] = 8'h11; mem[14'h0101] = 8'h22; mem[14'h0102] = 8'h33;
    r0 = rd_cnt;
    io_wr(8'h99, 8'h00); io_wr(8'h99, 8'h01); settle();
    chk("pf_cnt",  rd_cnt - r0, 1);
    chk("pf_addr", last_ra, 14'h0100);
    io_rd(8'h98, rdv); chk("ra_rd1", rdv, 8'h11);
    settle(); chk("ra_pf1", last_ra, 14'h0101);
    io_rd(8'h98, rdv); chk("ra_rd2", rdv, 8'h22);
    settle(); chk("ra_pf2", last_ra, 14'h0102);
    chk("ra_cnt", rd_cnt - r0, 3);

    // status and interrupt (reg1 bit5 already set)
    @(negedge clk) bus.int_pulse = 1'b1;
    @(negedge clk) bus.int_pulse = 1'b0;
    chk("nint_set", bus.n_int, 0);
    io_rd(8'h99, rdv); chk("stat_int", rdv, 8'h9F);
    chk("nint_clr", bus.n_int, 1);
    bus.fifth_spr = 1'b1; bus.fifth_num = 5'h0A;
    @(negedge clk) bus.coll_pulse = 1'b1;
    @(negedge clk) bus.coll_pulse = 1'b0;
    io_rd(8'h99, rdv); chk("stat_coll", rdv, 8'h6A);
    io_rd(8'h99, rdv); chk("stat_coll_clr", rdv, 8'h4A);
    bus.fifth_spr = 1'b0;
    @(negedge clk); bus.io_addr = 8'h99; bus.n_io_rd = 1'b0;
    @(negedge clk); bus.n_io_rd = 1'b1; bus.io_addr = 8'h00; bus.int_pulse = 1'b1;
    @(negedge clk); bus.int_pulse = 1'b0;
    chk("set_wins", bus.n_int, 0);
    io_rd(8'h99, rdv); chk("set_wins_stat", rdv, 8'h9F);
    chk("set_wins_clr", bus.n_int, 1);

    // toggle cleared by status read, then address wrap
    io_wr(8'h99, 8'h12); io_rd(8'h99, rdv);
    io_wr(8'h99, 8'hFF); io_wr(8'h99, 8'h7F);
    chk("tog_regs", bus.regs, 64'hF400_0000_0000_E0C5);
    io_wr(8'h98, 8'h77); settle();
    chk("wrap_top", last_wa, 14'h3FFF);
    io_wr(8'h98, 8'h78); settle();
    chk("wrap_zero", last_wa, 14'h0000);

    // data-port collision with a slow ack
    ack_delay = 10;
    io_wr(8'h99, 8'h00); io_wr(8'h99, 8'h42);
    w0 = wr_cnt;
    io_wr(8'h98, 8'hB1);
    @(negedge clk);
    bus.io_addr = 8'h98; bus.din = 8'hB2; bus.n_io_wr = 1'b0;
    #1 chk("coll_wait_ev", bus.wait_n, !WEN);
    @(negedge clk);
    chk("coll_wait_hold", bus.wait_n, !WEN);
    for (int i = 0; i < 100 && !bus.wait_n; i++) @(negedge clk);
    chk("coll_wait_rel", bus.wait_n, 1);
    bus.n_io_wr = 1'b1; bus.io_addr = 8'h00;
    settle();
    chk("coll_cnt",  wr_cnt - w0, WEN ? 2 : 1);
    chk("coll_addr", last_wa, WEN ? 14'h0201 : 14'h0200);
    chk("coll_data", last_wd, WEN ? 8'hB2 : 8'hB1);

    // asynchronous reset in the middle of an access
    io_wr(8'h98, 8'hC3);
    chk("mid_req", bus.vram_req, 1);
    @(negedge clk); #2 reset = 1'b1;
    #1 chk("mid_rst_req", bus.vram_req, 0);
    @(negedge clk); reset = 1'b0; ack_delay = 1;
    chk("mid_rst_regs", bus.regs, 0);
    w0 = wr_cnt;
    io_wr(8'h98, 8'hD4); settle();
    chk("post_rst_cnt",  wr_cnt - w0, 1);
    chk("post_rst_addr", last_wa, 14'h0000);
    chk("post_rst_data", last_wd, 8'hD4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
